// File: rtl/n_cobs_decoder_if.sv
// Stream bundle between the UART RX path, the COBS decoder and the dispatcher.
// The decoder sits on the slave side; the producer/consumer pair uses master.
interface n_cobs_decoder_if #(
    parameter int LenW = 9
);
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            out_err;
    logic            frame_done;
    logic [LenW-1:0] frame_len;

    modport slave (
        input  rx_data, rx_valid, out_ready,
        output rx_ready, out_data, out_valid, out_last, out_err,
        output frame_done, frame_len
    );

    modport master (
        output rx_data, rx_valid, out_ready,
        input  rx_ready, out_data, out_valid, out_last, out_err,
        input  frame_done, frame_len
    );
endinterface

// File: rtl/n_cobs_decoder.sv
// COBS stream decoder: strips code bytes, restores implicit zeros and
// closes frames on 0x00 with length, error and last-byte reporting.
module n_cobs_decoder #(
    parameter int MaxFrameLen = 256,
    parameter int LenW        = $clog2(MaxFrameLen + 1)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    n_cobs_decoder_if.slave bus
);
    localparam logic [LenW-1:0] LP_MAX = LenW'(MaxFrameLen);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_CODE,
        S_DRAIN
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_rem;
    logic            r_pend_zero;
    logic [7:0]      r_hold;
    logic            r_hold_full;
    logic [LenW-1:0] r_count;
    logic [7:0]      r_out_data;
    logic            r_out_valid;
    logic            r_out_last;
    logic            r_out_err;
    logic            r_frame_done;
    logic [LenW-1:0] r_frame_len;

    logic            w_rx_ready;
    logic            w_accept;
    logic            w_push;
    logic [7:0]      w_push_byte;
    logic            w_load_code;
    logic            w_dec;
    logic            w_close;
    logic            w_close_err;

    assign w_rx_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.rx_valid && w_rx_ready;

    assign bus.rx_ready   = w_rx_ready;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_last   = r_out_last;
    assign bus.out_err    = r_out_err;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_len  = r_frame_len;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_byte = bus.rx_data;
        w_load_code = 1'b0;
        w_dec       = 1'b0;
        w_close     = 1'b0;
        w_close_err = 1'b0;
        if (w_accept) begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.rx_data != 8'h00) begin
                        w_load_code = 1'b1;
                        w_state_nxt = (bus.rx_data > 8'd1) ? S_DATA : S_CODE;
                    end
                end
                S_DATA: begin
                    if (bus.rx_data == 8'h00) begin
                        w_close     = 1'b1;
                        w_close_err = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_push = 1'b1;
                        w_dec  = 1'b1;
                        if (r_rem == 8'd1) begin
                            w_state_nxt = S_CODE;
                        end
                    end
                end
                S_CODE: begin
                    if (bus.rx_data == 8'h00) begin
                        w_close     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_push      = r_pend_zero;
                        w_push_byte = 8'h00;
                        w_load_code = 1'b1;
                        w_state_nxt = (bus.rx_data > 8'd1) ? S_DATA : S_CODE;
                    end
                end
                S_DRAIN: begin
                    if (bus.rx_data == 8'h00) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        // A push past the limit turns into an error close of what we hold.
        if (w_push && (r_count == LP_MAX)) begin
            w_push      = 1'b0;
            w_load_code = 1'b0;
            w_dec       = 1'b0;
            w_close     = 1'b1;
            w_close_err = 1'b1;
            w_state_nxt = S_DRAIN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rem        <= 8'd0;
            r_pend_zero  <= 1'b0;
            r_hold       <= 8'd0;
            r_hold_full  <= 1'b0;
            r_count      <= '0;
            r_out_data   <= 8'd0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_err    <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_len  <= '0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_push) begin
                if (r_hold_full) begin
                    r_out_data  <= r_hold;
                    r_out_valid <= 1'b1;
                    r_out_last  <= 1'b0;
                    r_out_err   <= 1'b0;
                end
                r_hold      <= w_push_byte;
                r_hold_full <= 1'b1;
                r_count     <= r_count + LenW'(1);
            end
            if (w_load_code) begin
                r_rem       <= bus.rx_data - 8'd1;
                r_pend_zero <= (bus.rx_data != 8'hFF);
            end
            if (w_dec) begin
                r_rem <= r_rem - 8'd1;
            end
            if (w_close) begin
                if (r_hold_full) begin
                    r_out_data  <= r_hold;
                    r_out_valid <= 1'b1;
                    r_out_last  <= 1'b1;
                    r_out_err   <= w_close_err;
                end
                r_hold_full  <= 1'b0;
                r_pend_zero  <= 1'b0;
                r_count      <= '0;
                r_frame_done <= 1'b1;
                r_frame_len  <= r_count;
            end
        end
    end
endmodule

// File: tb/tb_n_cobs_decoder.sv
// Directed bench for the COBS decoder: a 256-byte instance and a 4-byte
// instance, each checked against queues of expected beats and frame lengths.
module tb_n_cobs_decoder;
    logic clk = 1'b0;
    logic reset_i;
    always #5 clk = ~clk;

    n_cobs_decoder_if #(.LenW(9)) bus ();
    n_cobs_decoder_if #(.LenW(3)) bus4 ();

    n_cobs_decoder #(.MaxFrameLen(256), .LenW(9)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    n_cobs_decoder #(.MaxFrameLen(4), .LenW(3)) dut4 (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus4.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [9:0] q0[$];
    logic [9:0] q4[$];
    int         l0[$];
    int         l4[$];
    logic [7:0] tx[$];

    int         mode = 0;
    logic       stall_seen = 1'b0;
    logic       prev_stall[2];
    logic [9:0] prev_beat[2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_b(input int s, input logic [7:0] d,
                         input logic l, input logic e);
        if (s == 0) q0.push_back({e, l, d});
        else        q4.push_back({e, l, d});
    endtask

    task automatic exp_l(input int s, input int n);
        if (s == 0) l0.push_back(n);
        else        l4.push_back(n);
    endtask

    task automatic mon(input int s, input logic v, input logic rdy,
                       input logic [9:0] beat, input logic fd,
                       input logic [8:0] fl);
        int n;
        logic [9:0] e;
        int el;
        if (prev_stall[s] && !reset_i) begin
            chk("stable", {22'd0, v, beat}, {22'd0, 1'b1, prev_beat[s]});
        end
        prev_stall[s] = v && !rdy && !reset_i;
        prev_beat[s]  = beat;
        if (v === 1'b1 && rdy === 1'b1) begin
            n = (s == 0) ? q0.size() : q4.size();
            chk("beat_avail", 32'(n != 0), 1);
            if (n != 0) begin
                e = (s == 0) ? q0.pop_front() : q4.pop_front();
                chk("beat", {22'd0, beat}, {22'd0, e});
            end
        end
        if (fd === 1'b1) begin
            n = (s == 0) ? l0.size() : l4.size();
            chk("len_avail", 32'(n != 0), 1);
            if (n != 0) begin
                el = (s == 0) ? l0.pop_front() : l4.pop_front();
                chk("frame_len", {23'd0, fl}, el);
            end
        end
    endtask

    task automatic send_byte(input int s, input logic [7:0] b);
        int n;
        logic ok;
        @(negedge clk);
        if (s == 0) begin
            bus.rx_data  = b;
            bus.rx_valid = 1'b1;
        end else begin
            bus4.rx_data  = b;
            bus4.rx_valid = 1'b1;
        end
        n = 0;
        forever begin
            #1;
            ok = (s == 0) ? bus.rx_ready : bus4.rx_ready;
            if (!ok) stall_seen = 1'b1;
            @(posedge clk);
            if (ok) break;
            n++;
            if (n > 50) begin
                chk("rx_timeout", n, 0);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int s);
        for (int i = 0; i < tx.size(); i++) send_byte(s, tx[i]);
        @(negedge clk);
        bus.rx_valid  = 1'b0;
        bus4.rx_valid = 1'b0;
    endtask

    // out_ready pattern generator for the consumer side
    initial begin
        logic [3:0] pat;
        int k;
        pat = 4'b1001;
        k = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (mode)
                1:       bus.out_ready = pat[3 - (k % 4)];
                2:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
            k++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            mon(0, bus.out_valid, bus.out_ready,
                {bus.out_err, bus.out_last, bus.out_data},
                bus.frame_done, bus.frame_len);
            mon(1, bus4.out_valid, bus4.out_ready,
                {bus4.out_err, bus4.out_last, bus4.out_data},
                bus4.frame_done, 9'(bus4.frame_len));
        end
    end

    initial begin
        int w;
        reset_i        = 1'b1;
        bus.rx_data    = 8'h00;
        bus.rx_valid   = 1'b0;
        bus4.rx_data   = 8'h00;
        bus4.rx_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_frame_len", bus.frame_len, 0);
        chk("rst_rx_ready", bus.rx_ready, 1);
        reset_i = 1'b0;

        // basic frame with one implicit zero
        exp_b(0, 8'h11, 0, 0);
        exp_b(0, 8'h22, 0, 0);
        exp_b(0, 8'h00, 0, 0);
        exp_b(0, 8'h33, 1, 0);
        exp_l(0, 4);
        tx = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
        send_frame(0);

        // full 254-byte block, no implicit zero
        tx = '{8'hFF};
        for (int i = 1; i <= 254; i++) begin
            tx.push_back(8'(i));
            exp_b(0, 8'(i), i == 254, 0);
        end
        tx.push_back(8'h00);
        exp_l(0, 254);
        send_frame(0);

        // premature delimiter then a clean frame
        exp_b(0, 8'hAA, 0, 0);
        exp_b(0, 8'hBB, 1, 1);
        exp_l(0, 2);
        exp_b(0, 8'h55, 1, 0);
        exp_l(0, 1);
        tx = '{8'h04, 8'hAA, 8'hBB, 8'h00, 8'h02, 8'h55, 8'h00};
        send_frame(0);

        // empty frames: only 01 00 reports a close
        exp_l(0, 0);
        tx = '{8'h00, 8'h00, 8'h01, 8'h00};
        send_frame(0);

        // back-pressure on the output
        stall_seen = 1'b0;
        mode = 1;
        exp_b(0, 8'h11, 0, 0);
        exp_b(0, 8'h22, 0, 0);
        exp_b(0, 8'h00, 0, 0);
        exp_b(0, 8'h33, 1, 0);
        exp_l(0, 4);
        tx = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
        send_frame(0);
        repeat (8) @(negedge clk);
        mode = 0;
        chk("rx_ready_dropped", stall_seen, 1);

        // reset with a beat stuck in the output register
        mode = 2;
        tx = '{8'h04, 8'h11, 8'h22};
        send_frame(0);
        repeat (2) @(negedge clk);
        #3;
        chk("stall_valid", bus.out_valid, 1);
        @(negedge clk);
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_valid", bus.out_valid, 0);
        chk("rst_mid_done", bus.frame_done, 0);
        @(negedge clk);
        reset_i = 1'b0;
        mode = 0;
        exp_b(0, 8'h55, 1, 0);
        exp_l(0, 1);
        tx = '{8'h02, 8'h55, 8'h00};
        send_frame(0);

        // oversize frame on the 4-byte instance, then recovery
        exp_b(1, 8'h01, 0, 0);
        exp_b(1, 8'h02, 0, 0);
        exp_b(1, 8'h03, 0, 0);
        exp_b(1, 8'h04, 1, 1);
        exp_l(1, 4);
        exp_b(1, 8'h55, 1, 0);
        exp_l(1, 1);
        tx = '{8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00,
               8'h02, 8'h55, 8'h00};
        send_frame(1);

        w = 0;
        while ((q0.size() + q4.size() + l0.size() + l4.size()) != 0
               && w < 500) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        chk("beats_left", q0.size() + q4.size(), 0);
        chk("lens_left", l0.size() + l4.size(), 0);
        chk("len_held", bus.frame_len, 1);
        chk("len_held4", bus4.frame_len, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
